// File: rtl/laser_pkg.sv
// Shared types and constants for the LASER frame transmitter.
package laser_pkg;

  localparam int unsigned NPTS      = 40;
  localparam int unsigned RADIUS_SQ = 16;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned TMO       = 4095;
  localparam int unsigned TMO_W     = 12;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    SEND,
    WAIT_DONE,
    SCORE,
    REPORT
  } state_e;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } point_t;

endpackage

// File: rtl/laser_cover_chk.sv
// Combinational in-circle test of one point against two centres.
// Only built when LASER_TX_COVER_EN is defined.
`ifdef LASER_TX_COVER_EN
module laser_cover_chk
  import laser_pkg::*;
(
  input  logic [3:0] px,
  input  logic [3:0] py,
  input  logic [3:0] c1x,
  input  logic [3:0] c1y,
  input  logic [3:0] c2x,
  input  logic [3:0] c2y,
  output logic       hit_c
);

  function automatic logic in_circle(input logic [3:0] ax, input logic [3:0] ay,
                                     input logic [3:0] cx, input logic [3:0] cy);
    logic [3:0] dx;
    logic [3:0] dy;
    logic [7:0] sx;
    logic [7:0] sy;
    logic [8:0] sum;
    dx  = (ax >= cx) ? ax - cx : cx - ax;
    dy  = (ay >= cy) ? ay - cy : cy - ay;
    sx  = 8'(dx) * 8'(dx);
    sy  = 8'(dy) * 8'(dy);
    sum = 9'(sx) + 9'(sy);
    return sum <= 9'(RADIUS_SQ);
  endfunction

  always_comb begin
    hit_c = in_circle(px, py, c1x, c1y) || in_circle(px, py, c2x, c2y);
  end

endmodule
`endif

// File: rtl/laser_frame_tx.sv
// Streams a 40-point frame to the LASER engine and latches the returned centres.
// Define LASER_TX_COVER_EN to add the SCORE pass and the res_cover output.
module laser_frame_tx
  import laser_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [3:0] wr_x,
  input  logic [3:0] wr_y,
  input  logic       start,
  output logic       busy,
  output logic [3:0] x,
  output logic [3:0] y,
  input  logic       done,
  input  logic [3:0] c1x,
  input  logic [3:0] c1y,
  input  logic [3:0] c2x,
  input  logic [3:0] c2y,
  output logic [3:0] res_c1x,
  output logic [3:0] res_c1y,
  output logic [3:0] res_c2x,
  output logic [3:0] res_c2y,
`ifdef LASER_TX_COVER_EN
  output logic [5:0] res_cover,
`endif
  output logic       res_valid,
  output logic       err
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;
  logic [3:0]         x_q, x_d, y_q, y_d;
  logic [3:0]         rc1x_q, rc1x_d, rc1y_q, rc1y_d, rc2x_q, rc2x_d, rc2y_q, rc2y_d;
  logic               res_valid_q, res_valid_d;
  logic               err_q, err_d;
  logic               wr_ok_c;
  point_t             send_pt_c;
  point_t             mem_q [NPTS];

  assign wr_ok_c = wr_en && (wr_addr < IDX_W'(NPTS)) && (state_q == IDLE);

  // Frame buffer: no reset, contents persist across frames and resets.
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem_q[wr_addr] <= {wr_x, wr_y};
  end

`ifdef LASER_TX_COVER_EN
  logic [5:0] cov_cnt_q, cov_cnt_d, res_cover_q, res_cover_d;
  point_t     score_pt_c;
  logic       hit_c;

  assign score_pt_c = mem_q[idx_q];

  laser_cover_chk u_cover_chk (
    .px   (score_pt_c.x),
    .py   (score_pt_c.y),
    .c1x  (rc1x_q),
    .c1y  (rc1y_q),
    .c2x  (rc2x_q),
    .c2y  (rc2y_q),
    .hit_c(hit_c)
  );

  assign res_cover = res_cover_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tmo_q       <= '0;
      rdy_q       <= 1'b1;
      busy_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      rc1x_q      <= '0;
      rc1y_q      <= '0;
      rc2x_q      <= '0;
      rc2y_q      <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef LASER_TX_COVER_EN
      cov_cnt_q   <= '0;
      res_cover_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      rdy_q       <= rdy_d;
      busy_q      <= busy_d;
      x_q         <= x_d;
      y_q         <= y_d;
      rc1x_q      <= rc1x_d;
      rc1y_q      <= rc1y_d;
      rc2x_q      <= rc2x_d;
      rc2y_q      <= rc2y_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
`ifdef LASER_TX_COVER_EN
      cov_cnt_q   <= cov_cnt_d;
      res_cover_q <= res_cover_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start) state_d = rdy_q ? SEND : WAIT_RDY;
      WAIT_RDY:  if (rdy_q) state_d = SEND;
      SEND:      if (idx_q == IDX_W'(NPTS - 1)) state_d = WAIT_DONE;
`ifdef LASER_TX_COVER_EN
      WAIT_DONE: if (done) state_d = SCORE;
                 else if (tmo_q == TMO_W'(TMO - 1)) state_d = REPORT;
      SCORE:     if (idx_q == IDX_W'(NPTS - 1)) state_d = REPORT;
`else
      WAIT_DONE: if (done || (tmo_q == TMO_W'(TMO - 1))) state_d = REPORT;
`endif
      REPORT:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    rdy_d       = rdy_q | done;
    x_d         = '0;
    y_d         = '0;
    rc1x_d      = rc1x_q;
    rc1y_d      = rc1y_q;
    rc2x_d      = rc2x_q;
    rc2y_d      = rc2y_q;
    err_d       = err_q;
    busy_d      = (state_d != IDLE);
    res_valid_d = (state_d == REPORT);
`ifdef LASER_TX_COVER_EN
    cov_cnt_d   = cov_cnt_q;
    res_cover_d = res_cover_q;
`endif
    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        if (start) err_d = 1'b0;
      end
      WAIT_RDY: idx_d = '0;
      SEND: begin
        idx_d = (idx_q == IDX_W'(NPTS - 1)) ? '0 : idx_q + IDX_W'(1);
        tmo_d = '0;
      end
      WAIT_DONE: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (done) begin
          rc1x_d = c1x;
          rc1y_d = c1y;
          rc2x_d = c2x;
          rc2y_d = c2y;
`ifdef LASER_TX_COVER_EN
          idx_d     = '0;
          cov_cnt_d = '0;
`endif
        end else if (state_d == REPORT) begin
          err_d = 1'b1;
        end
      end
`ifdef LASER_TX_COVER_EN
      SCORE: begin
        idx_d     = idx_q + IDX_W'(1);
        cov_cnt_d = cov_cnt_q + 6'(hit_c);
        if (state_d == REPORT) res_cover_d = cov_cnt_q + 6'(hit_c);
      end
`endif
      default: ;
    endcase
    // A write to slot 0 in the START cycle must reach the bus on the first point.
    if ((state_q == IDLE) && wr_ok_c && (wr_addr == '0)) send_pt_c = {wr_x, wr_y};
    else send_pt_c = mem_q[idx_d];
    if (state_d == SEND) begin
      x_d = send_pt_c.x;
      y_d = send_pt_c.y;
      if (state_q != SEND) rdy_d = 1'b0;
    end
  end

  assign busy      = busy_q;
  assign x         = x_q;
  assign y         = y_q;
  assign res_c1x   = rc1x_q;
  assign res_c1y   = rc1y_q;
  assign res_c2x   = rc2x_q;
  assign res_c2y   = rc2y_q;
  assign res_valid = res_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_laser_frame_tx.sv
// Self-checking bench for laser_frame_tx with an engine stub and a buffer model.
module tb_laser_frame_tx;

  localparam int N_PTS   = 40;
  localparam int TMO_CYC = 4095;

  logic       clk, rst_n, wr_en, start, done;
  logic [5:0] wr_addr;
  logic [3:0] wr_x, wr_y, c1x, c1y, c2x, c2y;
  logic       busy, res_valid, err;
  logic [3:0] x, y, res_c1x, res_c1y, res_c2x, res_c2y;
`ifdef LASER_TX_COVER_EN
  logic [5:0] res_cover;
  int         exp_cov_last;
`endif

  int         n_pass, n_total;
  logic [7:0] ref_mem [N_PTS];
  logic [3:0] exp_r [4];

  typedef struct {
    logic [3:0] px, py;
    int         dly;
    logic [3:0] a, b, c, d;
    int         cov;
  } vec_t;
  vec_t tbl [5];

  laser_frame_tx dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
    .start(start), .busy(busy), .x(x), .y(y), .done(done),
    .c1x(c1x), .c1y(c1y), .c2x(c2x), .c2y(c2y),
    .res_c1x(res_c1x), .res_c1y(res_c1y), .res_c2x(res_c2x), .res_c2y(res_c2y),
`ifdef LASER_TX_COVER_EN
    .res_cover(res_cover),
`endif
    .res_valid(res_valid), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [3:0] px, input logic [3:0] py);
    wr_en = 1'b1; wr_addr = 6'(a); wr_x = px; wr_y = py;
    tick();
    wr_en = 1'b0;
    if (a < N_PTS) ref_mem[a] = {px, py};
  endtask

  function automatic int cover_ref(input logic [3:0] a, b, c, d);
    int cnt = 0;
    for (int i = 0; i < N_PTS; i++) begin
      int px = int'(ref_mem[i][7:4]);
      int py = int'(ref_mem[i][3:0]);
      int d1 = (px - int'(a)) ** 2 + (py - int'(b)) ** 2;
      int d2 = (px - int'(c)) ** 2 + (py - int'(d)) ** 2;
      if (d1 <= 16 || d2 <= 16) cnt++;
    end
    return cnt;
  endfunction

  task automatic chk_res(input string tag);
    chk({tag, " res_c1x"}, res_c1x, exp_r[0]);
    chk({tag, " res_c1y"}, res_c1y, exp_r[1]);
    chk({tag, " res_c2x"}, res_c2x, exp_r[2]);
    chk({tag, " res_c2y"}, res_c2y, exp_r[3]);
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered at the first SEND cycle; leaves at the first WAIT_DONE cycle.
  task automatic stream_check(input string tag, input int poke_k);
    for (int k = 0; k < N_PTS; k++) begin
      chk($sformatf("%s x[%0d]", tag, k), x, ref_mem[k][7:4]);
      chk($sformatf("%s y[%0d]", tag, k), y, ref_mem[k][3:0]);
      chk($sformatf("%s busy[%0d]", tag, k), busy, 1);
      if (k == poke_k) begin
        start = 1'b1; wr_en = 1'b1;
        wr_addr = 6'($urandom_range(0, 39)); wr_x = 4'($urandom); wr_y = 4'($urandom);
      end
      tick();
      start = 1'b0; wr_en = 1'b0;
    end
    chk({tag, " x after frame"}, x, 0);
    chk({tag, " busy wait_done"}, busy, 1);
  endtask

  // Entered at the first WAIT_DONE cycle; engine answers after dly cycles.
  task automatic finish_done(input string tag, input logic [3:0] a, b, c, d,
                             input int dly, input bit poke_wr, input int exp_cov);
    chk({tag, " no early valid"}, res_valid, 0);
    for (int i = 0; i < dly; i++) begin
      if (poke_wr && i == 0) begin
        wr_en = 1'b1; wr_addr = 6'($urandom_range(0, 39));
        wr_x = 4'($urandom); wr_y = 4'($urandom);
      end
      tick();
      wr_en = 1'b0;
    end
    done = 1'b1; c1x = a; c1y = b; c2x = c; c2y = d;
    tick();
    done = 1'b0;
    c1x = 4'($urandom); c1y = 4'($urandom); c2x = 4'($urandom); c2y = 4'($urandom);
    exp_r[0] = a; exp_r[1] = b; exp_r[2] = c; exp_r[3] = d;
    chk_res(tag);
`ifdef LASER_TX_COVER_EN
    chk({tag, " valid in score"}, res_valid, 0);
    repeat (N_PTS) tick();
    chk({tag, " res_cover"}, res_cover, (exp_cov < 0) ? cover_ref(a, b, c, d) : exp_cov);
    exp_cov_last = int'(res_cover);
`endif
    chk({tag, " res_valid"}, res_valid, 1);
    chk({tag, " busy report"}, busy, 1);
    chk({tag, " err"}, err, 0);
    tick();
    chk({tag, " valid one cycle"}, res_valid, 0);
    chk({tag, " idle busy"}, busy, 0);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; wr_en = 1'b0; start = 1'b0; done = 1'b0;
    wr_addr = '0; wr_x = '0; wr_y = '0; c1x = '0; c1y = '0; c2x = '0; c2y = '0;
    for (int i = 0; i < 4; i++) exp_r[i] = '0;
`ifdef LASER_TX_COVER_EN
    exp_cov_last = 0;
`endif
    tbl[0] = '{4'd3,  4'd3,  2, 4'd3, 4'd3, 4'd11, 4'd11, 40};
    tbl[1] = '{4'd0,  4'd0,  0, 4'd3, 4'd3, 4'd11, 4'd11, 0};
    tbl[2] = '{4'd11, 4'd15, 5, 4'd0, 4'd0, 4'd11, 4'd11, 40};
    tbl[3] = '{4'd7,  4'd3,  1, 4'd3, 4'd3, 4'd15, 4'd0,  40};
    tbl[4] = '{4'd8,  4'd3,  3, 4'd3, 4'd3, 4'd11, 4'd11, 0};

    #12;
    chk("rst busy", busy, 0); chk("rst x", x, 0); chk("rst y", y, 0);
    chk("rst res_valid", res_valid, 0); chk("rst err", err, 0);
    chk_res("rst");
`ifdef LASER_TX_COVER_EN
    chk("rst res_cover", res_cover, 0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    // Uniform frames with hand-derived engine answers.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N_PTS; i++) wr(i, tbl[r].px, tbl[r].py);
      launch();
      stream_check($sformatf("tbl%0d", r), -1);
      finish_done($sformatf("tbl%0d", r), tbl[r].a, tbl[r].b, tbl[r].c, tbl[r].d,
                  tbl[r].dly, 1'b0, tbl[r].cov);
    end

    // Distinct points, then a slot-0 write in the same cycle as START.
    for (int i = 0; i < N_PTS; i++) wr(i, 4'(i), 4'(i * 7));
    wr(40, 4'hF, 4'hF);
    wr(63, 4'hE, 4'hE);
    wr_en = 1'b1; wr_addr = 6'd0; wr_x = 4'hA; wr_y = 4'h5; start = 1'b1;
    ref_mem[0] = 8'hA5;
    tick();
    wr_en = 1'b0; start = 1'b0;
    stream_check("wrstart", -1);
    finish_done("wrstart", 4'd1, 4'd2, 4'd13, 4'd14, 4, 1'b0, -1);

    // START and a write during SEND, a write during WAIT_DONE: all dropped.
    launch();
    stream_check("poke", 10);
    finish_done("poke", 4'd5, 4'd6, 4'd7, 4'd8, 3, 1'b1, -1);
    launch();
    stream_check("after poke", -1);
    finish_done("after poke", 4'd9, 4'd10, 4'd2, 4'd4, 0, 1'b0, -1);

    // Engine silent: timeout, then START waits for the engine to report idle.
    launch();
    stream_check("tmo", -1);
    repeat (TMO_CYC - 1) tick();
    chk("tmo valid early", res_valid, 0);
    chk("tmo err early", err, 0);
    tick();
    chk("tmo err", err, 1);
    chk("tmo res_valid", res_valid, 1);
    chk_res("tmo");
`ifdef LASER_TX_COVER_EN
    chk("tmo res_cover", res_cover, exp_cov_last);
`endif
    tick();
    chk("tmo valid one cycle", res_valid, 0);
    chk("tmo err sticky", err, 1);
    chk("tmo idle busy", busy, 0);
    launch();
    chk("wait_rdy err cleared", err, 0);
    chk("wait_rdy busy", busy, 1);
    repeat (3) tick();
    chk("wait_rdy x", x, 0);
    done = 1'b1; c1x = 4'd15; c1y = 4'd15; c2x = 4'd15; c2y = 4'd15;
    tick();
    done = 1'b0;
    chk_res("wait_rdy no capture");
    chk("wait_rdy still idle bus", x, 0);
    tick();
    stream_check("wait_rdy", -1);
    finish_done("wait_rdy", 4'd12, 4'd3, 4'd4, 4'd5, 6, 1'b0, -1);

    // Reset in the middle of SEND abandons the frame; the buffer survives.
    launch();
    repeat (20) tick();
    chk("mid x[20]", x, ref_mem[20][7:4]);
    rst_n = 1'b0;
    #1;
    chk("mid rst x", x, 0); chk("mid rst y", y, 0); chk("mid rst busy", busy, 0);
    for (int i = 0; i < 4; i++) exp_r[i] = '0;
    chk_res("mid rst");
`ifdef LASER_TX_COVER_EN
    chk("mid rst res_cover", res_cover, 0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    launch();
    stream_check("post rst", -1);
    finish_done("post rst", 4'd6, 4'd7, 4'd8, 4'd9, 2, 1'b0, -1);

    // Random buffer updates (some out of range) and engine answers.
    for (int r = 0; r < 6; r++) begin
      int nw = int'($urandom_range(10, 60));
      for (int i = 0; i < nw; i++) wr(int'($urandom_range(0, 63)), 4'($urandom), 4'($urandom));
      launch();
      stream_check($sformatf("rnd%0d", r), -1);
      finish_done($sformatf("rnd%0d", r), 4'($urandom), 4'($urandom), 4'($urandom),
                  4'($urandom), int'($urandom_range(0, 25)), 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
